// File: rtl/intt_controller.sv
// intt_controller: sequencer for a radix-R inverse NTT datapath.
// Walks L butterfly steps of N/R beats each, separated by PIPE drain cycles,
// and emits per-beat inverse twiddle exponents for lanes 1..R-1.
// Optional build macro: INTT_SCALE_EN adds an N/R-cycle N^-1 scaling phase
// before completion. When it is undefined, scale_en is tied low.
module intt_controller #(
    parameter int N    = 256,
    parameter int R    = 4,
    parameter int L    = 4,
    parameter int PIPE = 3
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    output logic                                 busy,
    output logic                                 done,
    output logic [L-1:0]                         bf_en,
    output logic [(R-1)*$clog2(N)-1:0]           tw_exp,
    output logic                                 scale_en
);

    localparam int LOGN    = $clog2(N);
    localparam int LOGR    = $clog2(R);
    localparam int BEATS   = N / R;
    localparam int CNT_MAX = (BEATS > PIPE) ? BEATS : PIPE;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int KW      = (L > 1) ? $clog2(L) : 1;
    localparam int TW      = (R - 1) * LOGN;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        DRAIN = 3'd2,
`ifdef INTT_SCALE_EN
        SCALE = 3'd3,
`endif
        DONE  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [CW-1:0]   b_q, b_d;
    logic            done_q, done_d;
    logic [L-1:0]    bf_en_q, bf_en_d;
    logic [TW-1:0]   tw_exp_q, tw_exp_d;
    logic [LOGN-1:0] mask_w;
    logic [LOGN-1:0] base_w;

    // Next-state logic: step index k and beat/drain counter b.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        k_d     = k_q;
        b_d     = b_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    k_d     = '0;
                    b_d     = '0;
                end
            end
            RUN: begin
                if (b_q == CW'(BEATS - 1)) begin
                    state_d = DRAIN;
                    b_d     = '0;
                end else begin
                    b_d = b_q + CW'(1);
                end
            end
            DRAIN: begin
                if (b_q == CW'(PIPE - 1)) begin
                    b_d = '0;
                    if (k_q == KW'(L - 1)) begin
`ifdef INTT_SCALE_EN
                        state_d = SCALE;
`else
                        state_d = DONE;
`endif
                    end else begin
                        state_d = RUN;
                        k_d     = k_q + KW'(1);
                    end
                end else begin
                    b_d = b_q + CW'(1);
                end
            end
`ifdef INTT_SCALE_EN
            SCALE: begin
                if (b_q == CW'(BEATS - 1)) begin
                    state_d = DONE;
                    b_d     = '0;
                end else begin
                    b_d = b_q + CW'(1);
                end
            end
`endif
            DONE: begin
                // start here is deliberately dropped; a new transform needs IDLE.
                state_d = IDLE;
                k_d     = '0;
                b_d     = '0;
            end
            default: begin
                state_d = IDLE;
                k_d     = '0;
                b_d     = '0;
            end
        endcase
    end

    // Output decode from the next state so the registered outputs line up with it.
    always_comb begin
        logic [LOGN-1:0] f;
        done_d   = (state_d == DONE);
        bf_en_d  = '0;
        tw_exp_d = '0;
        f        = '0;
        // Only the low log2(N/R^(k+1)) bits of b select a twiddle within a block;
        // R^k is a shift by k*log2(R).
        mask_w   = LOGN'((N >> ((int'(k_d) + 1) * LOGR)) - 1);
        base_w   = (LOGN'(b_d) & mask_w) << (int'(k_d) * LOGR);
        if (state_d == RUN) begin
            bf_en_d[k_d] = 1'b1;
            for (int i = 1; i < R; i++) begin
                // Forward exponent wraps mod N; negation mod N gives 0 for f=0.
                f = LOGN'(i) * base_w;
                tw_exp_d[(i-1)*LOGN +: LOGN] = LOGN'(0) - f;
            end
        end
    end

    // State, counters and registered outputs, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            k_q      <= '0;
            b_q      <= '0;
            done_q   <= 1'b0;
            bf_en_q  <= '0;
            tw_exp_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q  <= state_d;
            k_q      <= k_d;
            b_q      <= b_d;
            done_q   <= done_d;
            bf_en_q  <= bf_en_d;
            tw_exp_q <= tw_exp_d;
        end
    end

`ifdef INTT_SCALE_EN
    logic scale_en_q, scale_en_d;

    // Scaling enable asserted for the whole SCALE phase.
    always_comb begin
        scale_en_d = (state_d == SCALE);
    end

    // Registered scaling enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scale_en_q <= 1'b0;
        end else begin
            scale_en_q <= scale_en_d;
        end
    end

    assign scale_en = scale_en_q;
`else
    assign scale_en = 1'b0;
`endif

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign bf_en  = bf_en_q;
    assign tw_exp = tw_exp_q;

endmodule

// File: tb/tb_intt_controller.sv
// tb_intt_controller: scoreboard bench for intt_controller (N=256, R=4, L=4, PIPE=3).
// An accepted start pushes the whole expected per-cycle output sequence of the
// transform into a queue; a negedge monitor pops one entry per cycle and compares.
// Follows INTT_SCALE_EN the same way the design does.
module tb_intt_controller;

    localparam int N     = 256;
    localparam int R     = 4;
    localparam int L     = 4;
    localparam int PIPE  = 3;
    localparam int LOGN  = $clog2(N);
    localparam int TW    = (R - 1) * LOGN;
    localparam int BEATS = N / R;
`ifdef INTT_SCALE_EN
    localparam int DONE_CYCLE = 333;
`else
    localparam int DONE_CYCLE = 269;
`endif

    typedef struct packed {
        logic          busy;
        logic          done;
        logic [L-1:0]  bf;
        logic [TW-1:0] tw;
        logic          sc;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          busy;
    logic          done;
    logic [L-1:0]  bf_en;
    logic [TW-1:0] tw_exp;
    logic          scale_en;

    exp_t exp_q[$];
    logic model_busy;
    logic mon_en;
    int   checks;
    int   errors;

    intt_controller #(.N(N), .R(R), .L(L), .PIPE(PIPE)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .bf_en    (bf_en),
        .tw_exp   (tw_exp),
        .scale_en (scale_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: cycle-by-cycle outputs of one whole transform, from the
    // timing rules (steps of N/R beats plus PIPE drain) and the exponent formula.
    task automatic push_transform();
        exp_t e;
        int   period;
        period = BEATS + PIPE;
        for (int t = 0; t < L * period; t++) begin
            int s;
            int o;
            s = t / period;
            o = t % period;
            e = '0;
            e.busy = 1'b1;
            if (o < BEATS) begin
                e.bf[s] = 1'b1;
                for (int i = 1; i < R; i++) begin
                    int f;
                    f = (i * (o % (N / (R ** (s + 1)))) * (R ** s)) % N;
                    e.tw[(i-1)*LOGN +: LOGN] = LOGN'((N - f) % N);
                end
            end
            exp_q.push_back(e);
        end
`ifdef INTT_SCALE_EN
        for (int t = 0; t < BEATS; t++) begin
            e = '0;
            e.busy = 1'b1;
            e.sc   = 1'b1;
            exp_q.push_back(e);
        end
`endif
        e = '0;
        e.busy = 1'b1;
        e.done = 1'b1;
        exp_q.push_back(e);
    endtask

    // Monitor: one expected entry per cycle; an empty queue means idle outputs.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            e = '0;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            model_busy = e.busy;
            check("busy",     64'(busy),     64'(e.busy));
            check("done",     64'(done),     64'(e.done));
            check("bf_en",    64'(bf_en),    64'(e.bf));
            check("tw_exp",   64'(tw_exp),   64'(e.tw));
            check("scale_en", 64'(scale_en), 64'(e.sc));
        end
    end

    // Called at posedge+1: holds start for one cycle; model decides acceptance.
    task automatic pulse_start();
        logic acc;
        start = 1'b1;
        @(posedge clk);
        acc = rst_n && !model_busy;
        #1;
        start = 1'b0;
        if (acc) push_transform();
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((exp_q.size() > 0 || model_busy) && n < 1000) begin
            cycles(1);
            n++;
        end
        check({name, "_idle_timeout"}, 64'(n < 1000), 64'(1));
    endtask

    task automatic wait_done(input string name, input int base_cyc);
        int n;
        n = base_cyc;
        while (!done && n < 1000) begin
            cycles(1);
            n++;
        end
        check(name, 64'(n), 64'(DONE_CYCLE));
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        start      = 1'b0;
        mon_en     = 1'b0;
        model_busy = 1'b0;
        rst_n      = 1'b1;
        #2 rst_n   = 1'b0;
        #1;
        check("reset_busy",  64'(busy),   64'(0));
        check("reset_bf_en", 64'(bf_en),  64'(0));
        check("reset_tw",    64'(tw_exp), 64'(0));
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        cycles(3);

        // Directed timeline: start in cycle 0, extra start at cycle 100.
        pulse_start();
        check("c1_bf_en", 64'(bf_en), 64'(4'b0001));
        cycles(5);
        check("s0_b5_tw", 64'(tw_exp), 64'({8'd241, 8'd246, 8'd251}));
        cycles(58);
        check("c64_bf_en", 64'(bf_en), 64'(4'b0001));
        cycles(1);
        check("c65_drain_bf", 64'(bf_en), 64'(0));
        check("c65_drain_tw", 64'(tw_exp), 64'(0));
        cycles(3);
        check("c68_bf_en", 64'(bf_en), 64'(4'b0010));
        cycles(20);
        check("s1_b20_tw", 64'(tw_exp), 64'({8'd208, 8'd224, 8'd240}));
        cycles(12);
        pulse_start();
        cycles(109);
        check("s3_bf_en", 64'(bf_en), 64'(4'b1000));
        check("s3_tw", 64'(tw_exp), 64'(0));
        wait_done("done_cycle", 210);
        cycles(1);
        check("after_done_busy", 64'(busy), 64'(0));
        wait_idle("t1");
        cycles(4);

        // Abort by reset at cycle 150, restart at cycle 160.
        pulse_start();
        cycles(149);
        rst_n = 1'b0;
        exp_q.delete();
        model_busy = 1'b0;
        #1;
        check("abort_busy", 64'(busy),     64'(0));
        check("abort_bf",   64'(bf_en),    64'(0));
        check("abort_tw",   64'(tw_exp),   64'(0));
        check("abort_done", 64'(done),     64'(0));
        check("abort_sc",   64'(scale_en), 64'(0));
        #3;
        cycles(5);
        rst_n = 1'b1;
        cycles(5);
        check("post_reset_idle", 64'(busy), 64'(0));
        pulse_start();
        check("restart_bf", 64'(bf_en), 64'(4'b0001));
        check("restart_tw_b0", 64'(tw_exp), 64'(0));
        cycles(1);
        check("restart_tw_b1", 64'(tw_exp), 64'({8'd253, 8'd254, 8'd255}));
        wait_done("restart_done_cycle", 2);
        wait_idle("t2");

        // Randomized: gaps, stray starts while busy, start on DONE, random aborts.
        for (int it = 0; it < 6; it++) begin
            int gap;
            int n;
            gap = int'($urandom_range(0, 15));
            cycles(gap);
            pulse_start();
            for (int j = 0; j < 3; j++) begin
                cycles(int'($urandom_range(1, 120)));
                if (exp_q.size() > 1) pulse_start();
            end
            if ($urandom_range(0, 3) == 0 && exp_q.size() > 2) begin
                rst_n = 1'b0;
                exp_q.delete();
                model_busy = 1'b0;
                cycles(int'($urandom_range(1, 4)));
                rst_n = 1'b1;
                cycles(1);
            end else begin
                n = 0;
                while (exp_q.size() != 1 && n < 1000) begin
                    cycles(1);
                    n++;
                end
                if (exp_q.size() == 1) pulse_start();
            end
            wait_idle("rand");
        end

        cycles(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/intt_controller.md
INTT_CONTROLLER -- requirements
Module: intt_controller

Interface
REQ-001 Parameter N, default 256: transform length, power of R.
REQ-002 Parameter R, default 4: radix, power of 2.
REQ-003 Parameter L, default 4: stage count, log_R(N).
REQ-004 Parameter PIPE, default 3: butterfly pipeline drain cycles between steps.
REQ-005 clk  input  1  clock, rising-edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 start  input  1  one-cycle request to begin an inverse transform.
REQ-008 busy  output  1  high from the cycle after accepted start through the DONE cycle.
REQ-009 done  output  1  one-cycle pulse at completion.
REQ-010 bf_en  output  L  one-hot butterfly-step enable; all-zero outside RUN.
REQ-011 tw_exp  output  (R-1)*log2(N)  inverse twiddle exponents, lanes 1..R-1; lane i in bits [i*log2N-1 : (i-1)*log2N].
REQ-012 scale_en  output  1  N^-1 scaling enable (INTT_SCALE_EN builds only; else tied 0).

Function
REQ-013 FSM states: IDLE, RUN, DRAIN, SCALE, DONE.
REQ-014 IDLE -> RUN when start=1; step index k and beat counter b cleared to 0.
REQ-015 RUN lasts exactly N/R cycles per step; b increments 0..N/R-1 each cycle.
REQ-016 During RUN, bf_en[k]=1 and all other bits 0.
REQ-017 RUN at b=N/R-1 -> DRAIN; b cleared.
REQ-018 DRAIN lasts exactly PIPE cycles with bf_en=0 and tw_exp=0.
REQ-019 DRAIN end with k<L-1 -> RUN, k incremented; with k=L-1 -> SCALE (macro defined) or DONE.
REQ-020 SCALE lasts N/R cycles with scale_en=1, then -> DONE.
REQ-021 DONE lasts one cycle with done=1, then -> IDLE.
REQ-022 Forward exponent per lane i during RUN: f_i = i * (b mod (N/R^(k+1))) * R^k, taken mod N.
REQ-023 tw_exp lane i = (N - f_i) mod N; f_i=0 yields 0, never N.
REQ-024 All exponent arithmetic is log2(N) bits wide with wrap-around mod N; R^k is a left shift by k*log2(R).
REQ-025 bf_en, tw_exp, scale_en and done are registered outputs; they change only on clk edges.
REQ-026 start while busy=1 is ignored; no queuing.
REQ-027 start on the same cycle as DONE is ignored; the next transform needs start in IDLE.
REQ-028 Total busy time is L*(N/R+PIPE) cycles, plus N/R with INTT_SCALE_EN, plus 1 for DONE.

Reset
REQ-029 rst_n=0 forces state IDLE, k=0, b=0, busy=0, done=0, bf_en=0, tw_exp=0, scale_en=0, asynchronously.
REQ-030 Reset asserted mid-transform aborts it; no done pulse is emitted for the aborted transform.
REQ-031 After rst_n deassertion, the block stays in IDLE until start.

Configuration
REQ-032 Macro INTT_SCALE_EN defined: SCALE state present and scale_en is driven as specified.
REQ-033 INTT_SCALE_EN undefined: SCALE state and its logic are absent; scale_en is constant 0; final DRAIN -> DONE.

Verification (N=256, R=4, L=4, PIPE=3)
REQ-034 Reset then start pulse at cycle 0 -> bf_en=4'b0001 on cycles 1..64; then 0 for 3 cycles; 4'b0010 on cycles 68..131.
REQ-035 Step 0, b=5 -> lanes 1,2,3 = 251, 246, 241; step 1, b=20 -> lanes 1,2,3 = 240, 224, 208; step 3, any b -> all lanes 0.
REQ-036 INTT_SCALE_EN defined -> scale_en high on cycles 269..332 and done on cycle 333; undefined -> done on cycle 269 and scale_en never high.
REQ-037 Second start pulse at cycle 100 -> ignored, with the timeline identical to REQ-034/REQ-036.
REQ-038 rst_n low at cycle 150 -> all outputs 0 immediately; no done pulse; a new start at cycle 160 restarts at step 0, b=0.
